vit_patch_embed: RTL and testbench



---
 rtl/vit_pkg.sv | 36 +++
 rtl/patch_mac_lane.sv | 26 ++
 rtl/vit_patch_embed.sv | 145 ++++++++++++++
 tb/tb_vit_patch_embed.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// Shared types and fixed-point helpers for the ViT patch-embedding stage.
// The S_CLS state exists only when VIT_PATCH_CLS_EN is defined.
package vit_pkg;

`ifdef VIT_PATCH_CLS_EN
  typedef enum logic [2:0] {S_IDLE, S_CLS, S_ACCUM, S_WRITE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;
`endif

  // Wide enough to hold PATCH_PIX full products without overflow.
  function automatic int acc_width(input int data_width, input int patch_pix);
    return 2 * data_width + $clog2(patch_pix) + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Round half up, drop the fraction bits, add bias and position, then clamp.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input logic signed [63:0] bias,
                                                   input logic signed [63:0] pos,
                                                   input int frac, input int dw);
    logic signed [63:0] r;
    r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    return sat(r + bias + pos, dw);
  endfunction

endpackage

// File: rtl/patch_mac_lane.sv
// One embedding lane: accumulates the full-precision pixel*weight products of a patch.
module patch_mac_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 37
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] pix,
  input  logic signed [DATA_WIDTH-1:0] weight,
  output logic signed [ACC_W-1:0]      acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = (2*DATA_WIDTH)'(pix) * (2*DATA_WIDTH)'(weight);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/vit_patch_embed.sv
// Patch embedding: streams patch pixels through EMB_DIM MAC lanes, adds bias and position,
// and builds the token matrix. Define VIT_PATCH_CLS_EN to emit a class token as token 0.
module vit_patch_embed
  import vit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8,
  parameter int PATCH_PIX  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_WIDTH-1:0] W_proj    [PATCH_PIX*EMB_DIM],
  input  logic signed [DATA_WIDTH-1:0] b_proj    [EMB_DIM],
  input  logic signed [DATA_WIDTH-1:0] pos_emb   [SEQ_LEN*EMB_DIM],
  input  logic signed [DATA_WIDTH-1:0] cls_token [EMB_DIM],
  output logic signed [DATA_WIDTH-1:0] x_out     [SEQ_LEN*EMB_DIM],
  output logic                         done,
  output logic                         out_valid
);

  localparam int ACC_W = acc_width(DATA_WIDTH, PATCH_PIX);
  localparam int PIX_W = $clog2(PATCH_PIX);
  localparam int TOK_W = $clog2(SEQ_LEN);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PATCH_PIX - 1);
  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(SEQ_LEN - 1);

  state_t                         state, next_state;
  logic   [PIX_W-1:0]             pix_cnt;
  logic   [TOK_W-1:0]             tok;
  logic                           xfer;
  logic                           lane_clear;
  logic                           done_q;
  logic signed [DATA_WIDTH-1:0]   w_sel [EMB_DIM];
  logic signed [ACC_W-1:0]        acc   [EMB_DIM];

  assign pix_ready  = (state == S_ACCUM);
  assign xfer       = pix_valid && pix_ready;
  assign lane_clear = (state == S_WRITE) || (state == S_IDLE);
  assign done       = done_q;
  assign out_valid  = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state is assigned before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
`ifdef VIT_PATCH_CLS_EN
      S_IDLE:  if (start) next_state = S_CLS;
      S_CLS:   next_state = S_ACCUM;
`else
      S_IDLE:  if (start) next_state = S_ACCUM;
`endif
      S_ACCUM: if (xfer && pix_cnt == PIX_LAST) next_state = S_WRITE;
      S_WRITE: next_state = (tok == TOK_LAST) ? S_DONE : S_ACCUM;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      tok     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == S_WRITE) && (tok == TOK_LAST);
      if (state == S_IDLE && start) begin
        pix_cnt <= '0;
        tok     <= '0;
      end
`ifdef VIT_PATCH_CLS_EN
      if (state == S_CLS) tok <= TOK_W'(1);
`endif
      if (xfer) pix_cnt <= pix_cnt + 1'b1;
      if (state == S_WRITE) begin
        pix_cnt <= '0;
        tok     <= tok + 1'b1;
      end
    end
  end

  // Weight column for the current pixel, one entry per lane.
  always_comb begin
    for (int e = 0; e < EMB_DIM; e++) begin
      w_sel[e] = '0;
      for (int k = 0; k < PATCH_PIX; k++)
        if (pix_cnt == PIX_W'(k)) w_sel[e] = W_proj[k*EMB_DIM + e];
    end
  end

  for (genvar e = 0; e < EMB_DIM; e++) begin : g_lane
    patch_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (lane_clear),
      .en     (xfer),
      .pix    (pix_in),
      .weight (w_sel[e]),
      .acc    (acc[e])
    );
  end

  // NOTE: the token matrix is a register bank that must read back as zero after reset,
  // so every entry is reset explicitly rather than being treated as an uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SEQ_LEN*EMB_DIM; i++) x_out[i] <= '0;
    end else begin
`ifdef VIT_PATCH_CLS_EN
      if (state == S_CLS)
        for (int e = 0; e < EMB_DIM; e++)
          x_out[e] <= DATA_WIDTH'(sat(64'(cls_token[e]) + 64'(pos_emb[e]), DATA_WIDTH));
`endif
      if (state == S_WRITE)
        for (int t = 0; t < SEQ_LEN; t++)
          for (int e = 0; e < EMB_DIM; e++)
            if (tok == TOK_W'(t))
              x_out[t*EMB_DIM + e] <= DATA_WIDTH'(sat_round(64'(acc[e]), 64'(b_proj[e]),
                                          64'(pos_emb[t*EMB_DIM + e]), FRAC_BITS, DATA_WIDTH));
    end
  end

`ifndef VIT_PATCH_CLS_EN
  // Class token has no consumer in this build.
  logic cls_unused;
  always_comb begin
    cls_unused = 1'b0;
    for (int e = 0; e < EMB_DIM; e++) cls_unused = cls_unused ^ (^cls_token[e]);
  end
`endif

endmodule

// File: tb/tb_vit_patch_embed.sv
// Self-checking bench for vit_patch_embed; honours VIT_PATCH_CLS_EN when defined.
module tb_vit_patch_embed;

  localparam int DW = 16, FB = 8, SL = 8, ED = 8, PP = 16;
  localparam int NX = SL * ED, NW = PP * ED;
`ifdef VIT_PATCH_CLS_EN
  localparam bit CLS = 1'b1;
`else
  localparam bit CLS = 1'b0;
`endif
  localparam int NPATCH = CLS ? SL - 1 : SL;
  localparam int LAT    = CLS ? (SL - 1) * (PP + 1) + 2 : SL * (PP + 1) + 1;

  logic                 clk, rst, start, pix_valid, pix_ready, done, out_valid;
  logic signed [DW-1:0] pix_in;
  logic signed [DW-1:0] w_proj    [NW];
  logic signed [DW-1:0] b_proj    [ED];
  logic signed [DW-1:0] pos_emb   [NX];
  logic signed [DW-1:0] cls_token [ED];
  logic signed [DW-1:0] x_out     [NX];

  logic signed [DW-1:0] pix_mem [SL*PP];
  longint               exp_x   [NX];
  int                   n_vec, n_err, n_xfer, frames_done;
  bit                   valid_en, toggle_mode, phase;

  vit_patch_embed #(
    .DATA_WIDTH (DW), .FRAC_BITS (FB), .SEQ_LEN (SL), .EMB_DIM (ED), .PATCH_PIX (PP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .W_proj    (w_proj),
    .b_proj    (b_proj),
    .pos_emb   (pos_emb),
    .cls_token (cls_token),
    .x_out     (x_out),
    .done      (done),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transfers counted by the bench, restarted with each frame.
  always @(posedge clk or posedge rst) begin
    if (rst || start)                n_xfer <= 0;
    else if (pix_valid && pix_ready) n_xfer <= n_xfer + 1;
  end

  // Pixel driver: pixel index follows the transfer count.
  initial begin
    pix_valid = 1'b0;
    pix_in    = '0;
    phase     = 1'b0;
    forever begin
      @(negedge clk);
      phase     = ~phase;
      pix_valid = valid_en && (!toggle_mode || phase);
      pix_in    = pix_mem[(n_xfer < SL*PP) ? n_xfer : 0];
    end
  end

  // Reference model: straight matrix arithmetic from the fixed-point rules.
  function automatic longint clamp(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic build_expected();
    for (int t = 0; t < SL; t++) begin
      for (int e = 0; e < ED; e++) begin
        if (CLS && t == 0) begin
          exp_x[e] = clamp(longint'(cls_token[e]) + longint'(pos_emb[e]));
        end else begin
          longint sum;
          int     p;
          p   = CLS ? t - 1 : t;
          sum = 0;
          for (int k = 0; k < PP; k++)
            sum += longint'(pix_mem[p*PP + k]) * longint'(w_proj[k*ED + e]);
          exp_x[t*ED + e] = clamp(((sum + 128) >>> 8) + longint'(b_proj[e]) + longint'(pos_emb[t*ED + e]));
        end
      end
    end
  endtask

  // Compare process: whenever a frame completes, the whole matrix must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (done || out_valid)) begin
        check("out_valid_eq_done", out_valid, done);
        check("pix_ready_in_done", pix_ready, 0);
        check("transfers", n_xfer, NPATCH * PP);
        for (int i = 0; i < NX; i++) check($sformatf("x_out[%0d]", i), x_out[i], exp_x[i]);
        frames_done++;
      end
    end
  end

  task automatic load(input int pv, input int wv, input int bv, input int posv, input int cv);
    for (int i = 0; i < SL*PP; i++) pix_mem[i] = DW'(pv);
    for (int i = 0; i < NW; i++)    w_proj[i]  = DW'(wv);
    for (int i = 0; i < ED; i++)    b_proj[i]  = DW'(bv);
    for (int i = 0; i < NX; i++)    pos_emb[i] = DW'(posv);
    for (int i = 0; i < ED; i++)    cls_token[i] = DW'(cv);
    build_expected();
  endtask

  task automatic run_frame(input bit tog, output int lat);
    @(negedge clk);
    toggle_mode = tog;
    valid_en    = 1'b1;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!done) check("frame_timeout", 0, 1);
    valid_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, guard, done_seen;
    n_vec = 0; n_err = 0; frames_done = 0;
    rst = 1'b1; start = 1'b0; valid_en = 1'b0; toggle_mode = 1'b0;
    load(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    for (int i = 0; i < NX; i++) check("rst_x_out", x_out[i], 0);
    rst = 1'b0;

    // Bias only: every entry 1.0, latency pinned.
    load(16'h0123, 0, 16'h0100, 0, 0);
    run_frame(1'b0, lat);
    check("latency", lat, LAT);
    check("t1_literal", x_out[NX-1], 64'sh0100);

    // 16 x (1.0 * 0.5) = 8.0
    load(16'h0100, 16'h0080, 0, 0, 0);
    run_frame(1'b0, lat);
    check("t2_literal", x_out[NX-1], 64'sh0800);

    // Saturation at both ends
    load(16'h7FFF, 16'h7FFF, 0, 0, 0);
    run_frame(1'b0, lat);
    check("sat_hi_literal", x_out[NX-1], 64'sh7FFF);
    load(16'h7FFF, 16'h8000, 0, 0, 0);
    run_frame(1'b0, lat);
    check("sat_lo_literal", x_out[NX-1], -64'sh8000);

    // Stalling source: same result as the unstalled frame
    load(16'h0100, 16'h0080, 0, 0, 0);
    run_frame(1'b1, lat);
    check("toggle_literal", x_out[0 + (CLS ? ED : 0)], 64'sh0800);

    // Reset in the middle of a frame
    @(negedge clk);
    toggle_mode = 1'b0; valid_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (n_xfer < 3*PP + 5 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_done", done, 0);
    for (int i = 0; i < NX; i++) check("midrst_x_out", x_out[i], 0);
    @(negedge clk);
    rst = 1'b0; valid_en = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no_done_after_rst", done_seen, 0);
    run_frame(1'b0, lat);
    check("after_rst_latency", lat, LAT);

    // Varied pixels, weights, bias and position
    for (int i = 0; i < SL*PP; i++) pix_mem[i] = DW'((i * 37) % 512 - 256);
    for (int i = 0; i < NW; i++)    w_proj[i]  = DW'((i * 13) % 64 - 32);
    for (int i = 0; i < ED; i++)    b_proj[i]  = DW'(i * 16 - 50);
    for (int i = 0; i < NX; i++)    pos_emb[i] = DW'(i - 32);
    build_expected();
    run_frame(1'b0, lat);

`ifdef VIT_PATCH_CLS_EN
    load(0, 0, 0, 16'h0010, 16'h0200);
    run_frame(1'b0, lat);
    check("cls_token_literal", x_out[0], 64'sh0210);
    check("cls_patch_literal", x_out[NX-1], 64'sh0010);
`endif

    check("frames_completed", frames_done, CLS ? 8 : 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule
